band_window_capture: RTL
========================

Name: band_window_capture

Overview:
- Downstream consumer of the tiranga band/chakra waveform stage.
- Watches one synchronous, ungated band level, band_i. For each high window it records the start cycle and the length.
- Completed records are buffered in a small FIFO and drained over a valid/ready interface to a checker or logger.
- Lets benches and on-chip debug confirm band placement numerically instead of by eye.

Parameters:
- CNT_W, 32, width of the free-running cycle counter, start field and length field.
- DEPTH, 4, number of FIFO record entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- band_i  input  1  band level, sampled on posedge clk; must not be clk-gated.
- rec_valid_o  output  1  FIFO head record is valid.
- rec_ready_i  input  1  consumer accepts the head record.
- rec_start_o  output  CNT_W  cnt_q value at the first high sample of the window.
- rec_len_o  output  CNT_W  number of consecutive high samples in the window.
- overflow_o  output  1  sticky flag: a completed record was dropped because the FIFO was full.
- busy_o  output  1  a window is currently open (state ACTIVE).

Behaviour:
- Reset values: cnt_q=0, state=IDLE, FIFO empty, rec_valid_o=0, rec_start_o=0, rec_len_o=0, overflow_o=0, busy_o=0.
- Counter: cnt_q increments by 1 every cycle and wraps from all-ones to 0. Start values near the wrap are legal; length is unaffected by the wrap.
- FSM states: IDLE, ACTIVE.
- IDLE, band_i=1 sampled at an edge where cnt_q=N:
  - start_q<=N, len_q<=1, go to ACTIVE.
- ACTIVE, band_i=1:
  - len_q<=len_q+1, saturating at all-ones; it never wraps.
- ACTIVE, band_i=0:
  - Push {start_q, len_q} into the FIFO on this edge, return to IDLE.
  - If band_i returns high on the next edge, a new window opens normally; windows may be separated by a single low cycle.
- busy_o equals (state==ACTIVE).
- Latency: the record is visible on the outputs with rec_valid_o=1 the cycle after the edge that samples band_i low.
- FIFO:
  - Registered, first-in first-out.
  - rec_valid_o equals not-empty.
  - Outputs show the head entry.
  - Outputs hold their value while rec_valid_o=1 and rec_ready_i=0.
  - Pop on valid&ready.
- Full FIFO plus push:
  - With a same-cycle pop: pop and push both happen and nothing is lost.
  - Without a pop: the record is dropped and overflow_o<=1. overflow_o stays high until reset.
- Empty FIFO: rec_ready_i is ignored. When empty, rec_start_o/rec_len_o hold their last value (0 after reset).
- Simultaneous push and pop on an empty FIFO is impossible, because the push becomes visible the next cycle.
- Reset mid-window: the open window is discarded, FIFO contents are lost, and the counter returns to 0.
- band_i high on the first edge after reset release opens a window with start=0.

Optional Feature:
- Macro: BAND_WINDOW_GAP_EN.
- When defined:
  - Adds output rec_gap_o (CNT_W), which is part of each record.
  - Gap equals the number of low samples between the previous window's end and this window's start, saturating.
  - The first window after reset reports its gap counted from reset release.
  - The gap counter resets to 0 on each window open.
- When undefined: no port, no gap counter, and the record carries start and length only.

Decomposition:
- Package band_pkg:
  - typedef state_t enum {IDLE, ACTIVE}.
  - typedef band_rec_t packed struct {start, len, gap under the macro}, parameterised through a package localparam CNT_W_DEF=32.
  - Function sat_inc.
- Sub-module band_rec_fifo:
  - Generic DEPTH-entry synchronous FIFO of band_rec_t.
  - Ports: push, full, pop, empty, head.
  - Pointers with an extra wrap bit.
- Top level holds the counter, FSM and overflow logic.

Test Plan:
- Single window: band_i high for cnt 450..550, rec_ready_i=1 → one record start=450, len=101; rec_valid_o rises the cycle after cnt 551; overflow_o=0.
- Mirrored bands: band_i high for 450..469 and 531..550 → records (450,20) then (531,20), in order.
- Backpressure: rec_ready_i=0, five 3-cycle windows separated by 2-cycle gaps, DEPTH=4 → four records held, overflow_o=1. Drain yields the first four in order; the fifth is lost.
- Full with simultaneous pop: FIFO full, rec_ready_i=1 on the exact push edge → no drop, overflow_o stays 0, and the count of records stays 4.
- Reset mid-window: band_i high from cnt 10, reset asserted at cnt 15 and released → busy_o=0, rec_valid_o=0, cnt_q=0, no record. A new window starting at cnt 3 reports start=3.
- Saturation and wrap, with CNT_W=4 override: band_i high for 20 cycles starting at cnt 14 → start=14, len=15 (saturated).
- Gap, with BAND_WINDOW_GAP_EN defined: windows 450..469 and 531..550 → second record reports gap=61.

Source files
------------

// File: rtl/band_window_capture_pkg.sv
// Shared types and helpers for band_window_capture and its record FIFO.
// BAND_WINDOW_GAP_EN adds a gap field to each record.
package band_pkg;
    localparam int CNT_W_DEF = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] start;
        logic [CNT_W_DEF-1:0] len;
`ifdef BAND_WINDOW_GAP_EN
        logic [CNT_W_DEF-1:0] gap;
`endif
    } band_rec_t;

    // Callers narrower than CNT_W_DEF pass their own all-ones as max_v.
    function automatic logic [CNT_W_DEF-1:0] sat_inc(input logic [CNT_W_DEF-1:0] v,
                                                      input logic [CNT_W_DEF-1:0] max_v);
        return (v >= max_v) ? max_v : v + CNT_W_DEF'(1);
    endfunction
endpackage

// File: rtl/band_window_capture_fifo.sv
// Generic DEPTH-entry synchronous FIFO of window records; pointers carry a wrap bit.
module band_rec_fifo
    import band_pkg::*;
#(
    parameter type rec_t = band_rec_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  rec_t push_rec,
    output logic full,
    input  logic pop,
    output logic empty,
    output rec_t head
);
    localparam int AW = $clog2(DEPTH);

    rec_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_rec;
    end
endmodule

// File: rtl/band_window_capture.sv
// Records start cycle and length of each high window on band_i into a small FIFO.
// Define BAND_WINDOW_GAP_EN to also report the low gap preceding each window.
module band_window_capture
    import band_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             band_i,
    output logic             rec_valid_o,
    input  logic             rec_ready_i,
    output logic [CNT_W-1:0] rec_start_o,
    output logic [CNT_W-1:0] rec_len_o,
`ifdef BAND_WINDOW_GAP_EN
    output logic [CNT_W-1:0] rec_gap_o,
`endif
    output logic             overflow_o,
    output logic             busy_o
);
    typedef struct packed {
        logic [CNT_W-1:0] start;
        logic [CNT_W-1:0] len;
`ifdef BAND_WINDOW_GAP_EN
        logic [CNT_W-1:0] gap;
`endif
    } rec_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] start_q;
    logic [CNT_W-1:0] len_q;
`ifdef BAND_WINDOW_GAP_EN
    logic [CNT_W-1:0] gap_cnt_q;
    logic [CNT_W-1:0] gap_q;
`endif
    rec_t             push_rec;
    rec_t             head;
    rec_t             hold_q;
    rec_t             shown;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign push = (state_q == ACTIVE) && !band_i;
    assign pop  = !empty && rec_ready_i;

    always_comb begin
        push_rec       = '0;
        push_rec.start = start_q;
        push_rec.len   = len_q;
`ifdef BAND_WINDOW_GAP_EN
        push_rec.gap   = gap_q;
`endif
    end

    band_rec_fifo #(
        .rec_t (rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_rec (push_rec),
        .full     (full),
        .pop      (pop),
        .empty    (empty),
        .head     (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            state_q    <= IDLE;
            start_q    <= '0;
            len_q      <= '0;
            overflow_o <= 1'b0;
            hold_q     <= '0;
`ifdef BAND_WINDOW_GAP_EN
            gap_cnt_q  <= '0;
            gap_q      <= '0;
`endif
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            case (state_q)
                IDLE: begin
                    if (band_i) begin
                        start_q <= cnt_q;
                        len_q   <= CNT_W'(1);
`ifdef BAND_WINDOW_GAP_EN
                        gap_q   <= gap_cnt_q;
`endif
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (band_i) len_q <= CNT_W'(sat_inc(CNT_W_DEF'(len_q), CNT_W_DEF'(CNT_MAX)));
                    else        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (push && full && !pop) overflow_o <= 1'b1;
            // Remember what was on display so an empty FIFO keeps showing it.
            if (!empty) hold_q <= head;
`ifdef BAND_WINDOW_GAP_EN
            gap_cnt_q <= band_i ? '0 : CNT_W'(sat_inc(CNT_W_DEF'(gap_cnt_q), CNT_W_DEF'(CNT_MAX)));
`endif
        end
    end

    assign shown       = empty ? hold_q : head;
    assign rec_valid_o = !empty;
    assign rec_start_o = shown.start;
    assign rec_len_o   = shown.len;
`ifdef BAND_WINDOW_GAP_EN
    assign rec_gap_o   = shown.gap;
`endif
    assign busy_o      = (state_q == ACTIVE);
endmodule
